// File: rtl/bootdata_packer_pkg.sv
// Shared constants for the boot data path: word geometry and handshake state codes.
// The ROM bootloader imports the same word geometry.
package bootdata_packer_pkg;
    localparam int WORD_W         = 32;
    localparam int BYTES_PER_WORD = 4;
    localparam int IDX_W          = $clog2(BYTES_PER_WORD);

    typedef logic [1:0] hs_state_t;
    localparam hs_state_t HS_IDLE    = 2'd0;
    localparam hs_state_t HS_REQ     = 2'd1;
    localparam hs_state_t HS_RELEASE = 2'd2;
    localparam hs_state_t HS_ABORT   = 2'd3;

    // Left-justify the n most recent bytes (held in the low end) and fill the rest with pad.
    function automatic logic [WORD_W-1:0] pad_word(input logic [WORD_W-1:0] w,
                                                   input logic [IDX_W-1:0] n,
                                                   input logic [7:0] pad);
        case (n)
            2'd1:    return {w[7:0], pad, pad, pad};
            2'd2:    return {w[15:0], pad, pad};
            2'd3:    return {w[23:0], pad};
            default: return w;
        endcase
    endfunction
endpackage

// File: rtl/boot_word_handshake.sv
// Hold register plus four-phase req/ack handshake toward the bootloader.
// Counts completed handshakes; abort drops the held word and parks until ack is low.
module boot_word_handshake
    import bootdata_packer_pkg::*;
#(
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   abort,
    input  logic [WORD_W-1:0]      word_in,
    input  logic                   word_valid,
    output logic                   word_free,
    output logic                   idle,
    output logic [WORD_W-1:0]      host_bootdata,
    output logic                   host_bootdata_req,
    input  logic                   host_bootdata_ack,
    output logic [COUNT_WIDTH-1:0] words_sent
);
    hs_state_t        state, state_nx;
    logic             req_nx, release_done, hold_valid;
    logic [WORD_W-1:0] hold;

    assign word_free     = !hold_valid;
    assign idle          = (state == HS_IDLE);
    assign host_bootdata = hold;

    always_comb begin
        state_nx     = state;
        req_nx       = host_bootdata_req;
        release_done = 1'b0;
        case (state)
            // Waiting for ack low keeps a new req from rising while a stale ack is still up.
            HS_IDLE:    if (hold_valid && !host_bootdata_ack) begin
                            req_nx   = 1'b1;
                            state_nx = HS_REQ;
                        end
            HS_REQ:     if (host_bootdata_ack) begin
                            req_nx   = 1'b0;
                            state_nx = HS_RELEASE;
                        end
            HS_RELEASE: if (!host_bootdata_ack) begin
                            release_done = 1'b1;
                            state_nx     = HS_IDLE;
                        end
            default:    begin
                            req_nx = 1'b0;
                            if (!host_bootdata_ack) state_nx = HS_IDLE;
                        end
        endcase
        if (abort) begin
            req_nx       = 1'b0;
            release_done = 1'b0;
            state_nx     = (host_bootdata_ack || state == HS_REQ || state == HS_RELEASE)
                           ? HS_ABORT : HS_IDLE;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state             <= HS_IDLE;
            host_bootdata_req <= 1'b0;
            hold              <= '0;
            hold_valid        <= 1'b0;
            words_sent        <= '0;
        end else begin
            state             <= state_nx;
            host_bootdata_req <= req_nx;
            if (abort) begin
                hold_valid <= 1'b0;
                words_sent <= '0;
            end else if (release_done) begin
                hold_valid <= 1'b0;
                words_sent <= words_sent + COUNT_WIDTH'(1);
            end else if (word_valid && !hold_valid) begin
                hold       <= word_in;
                hold_valid <= 1'b1;
            end
        end
    end
endmodule

// File: rtl/bootdata_packer.sv
// Packs a byte stream into big-endian 32-bit words for the ROM bootloader,
// with end-of-image padding (flush) and a clean abort.
module bootdata_packer
    import bootdata_packer_pkg::*;
#(
    parameter logic [7:0] PAD_BYTE    = 8'hFF,
    parameter int         COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [7:0]             byte_data,
    input  logic                   byte_valid,
    output logic                   byte_ready,
    input  logic                   flush,
    input  logic                   abort,
    output logic [WORD_W-1:0]      host_bootdata,
    output logic                   host_bootdata_req,
    input  logic                   host_bootdata_ack,
    output logic                   busy,
    output logic [COUNT_WIDTH-1:0] words_sent
);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_WORD - 1);

    logic [WORD_W-1:0] asm_word, word_acc;
    logic [IDX_W-1:0]  idx, idx_acc;
    logic              asm_full, accept, fill, word_free, idle;

    assign byte_ready = !asm_full;
    assign accept     = byte_valid && !asm_full && !abort;

    // Post-accept view, so a flush in the same cycle pads from the new index.
    always_comb begin
        word_acc = asm_word;
        idx_acc  = idx;
        if (accept) begin
            word_acc = {asm_word[WORD_W-9:0], byte_data};
            idx_acc  = idx + IDX_W'(1);
        end
    end

    // idx_acc wraps to 0 when the accepted byte completes the word, which makes flush a no-op.
    assign fill = flush && !asm_full && (idx_acc != '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            asm_word <= '0;
            idx      <= '0;
            asm_full <= 1'b0;
        end else if (abort) begin
            idx      <= '0;
            asm_full <= 1'b0;
        end else begin
            asm_word <= fill ? pad_word(word_acc, idx_acc, PAD_BYTE) : word_acc;
            idx      <= fill ? '0 : idx_acc;
            if (fill || (accept && idx == LAST_IDX))
                asm_full <= 1'b1;
            else if (asm_full && word_free)
                asm_full <= 1'b0;
        end
    end

    boot_word_handshake #(.COUNT_WIDTH(COUNT_WIDTH)) u_hs (
        .clk               (clk),
        .reset_n           (reset_n),
        .abort             (abort),
        .word_in           (asm_word),
        .word_valid        (asm_full),
        .word_free         (word_free),
        .idle              (idle),
        .host_bootdata     (host_bootdata),
        .host_bootdata_req (host_bootdata_req),
        .host_bootdata_ack (host_bootdata_ack),
        .words_sent        (words_sent)
    );

    assign busy = (idx != '0) | asm_full | !word_free | !idle;
endmodule
